alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Downstream consumer of the BCD wall-clock (hourdec/hourone/mindec/minone) produced by the watch stage.
//  Holds a user-set alarm time, detects the first cycle the running time equals it, then runs the
//  ring/snooze state machine and drives the buzzer tone. Runs on the fast system clock;
//  seconds are counted through a one-cycle sec_tick strobe derived from the same clock.
// PARAMETERS
//  RING_SEC    60    seconds of unattended ringing before auto-stop (>=1)
//  SNOOZE_MIN  5     snooze length in minutes (>=1); counter loads SNOOZE_MIN*60 seconds
//  TONE_DIV    1000  buzz half-period in clk cycles (>=1)
//  MAX_SNOOZE  3     snoozes allowed per alarm event (used only with SNOOZE_LIMIT_EN)
// PORTS
//  clk            in   1  system clock
//  rstn           in   1  asynchronous active-low reset
//  sec_tick       in   1  one-clk pulse per second
//  hourdec_now    in   4  current time, BCD hour tens (0-2)
//  hourone_now    in   4  current time, BCD hour units (0-9)
//  mindec_now     in   4  current time, BCD minute tens (0-5)
//  minone_now     in   4  current time, BCD minute units (0-9)
//  set_alarm      in   1  one-clk strobe: load the four *_set digits as alarm time
//  hourdec_set    in   4  alarm hour tens
//  hourone_set    in   4  alarm hour units
//  mindec_set     in   4  alarm minute tens
//  minone_set     in   4  alarm minute units
//  arm            in   1  level: alarm enabled
//  stop           in   1  one-clk pulse: silence and end alarm event
//  snooze         in   1  one-clk pulse: silence and restart after SNOOZE_MIN
//  ringing        out  1  state==RING
//  snoozing       out  1  state==SNOOZE
//  buzz           out  1  square-wave tone, 0 unless ringing
//  set_err        out  1  one-clk pulse: rejected set_alarm
// BEHAVIOUR
//  Reset: alarm regs = 00:00, state IDLE, ringing/snoozing/buzz/set_err = 0, counters 0, match_q = 1.
//  set_alarm: accepted when hourdec<=2, hourone<=9, mindec<=5, minone<=9 and hour<=23; alarm regs update next edge.
//   Otherwise alarm regs unchanged, set_err=1 for exactly one cycle. set_alarm never changes state.
//  match = (now digits == alarm regs), combinational; match_q = match registered each cycle.
//  trigger = arm & match & ~match_q (rising edge only: one event per matching minute; no ring right after reset).
//  FSM (all outputs registered, 1-cycle latency from the triggering input cycle):
//   IDLE:   trigger -> RING, ring_cnt=0.
//   RING:   sec_tick -> ring_cnt++; when ring_cnt reaches RING_SEC -> IDLE.
//           stop -> IDLE; snooze -> SNOOZE, snz_cnt = SNOOZE_MIN*60.
//   SNOOZE: sec_tick -> snz_cnt--; when snz_cnt reaches 0 -> RING, ring_cnt=0. stop -> IDLE.
//           snooze pulse in SNOOZE ignored.
//  Priority (same cycle): ~arm > stop > snooze > sec_tick timeout. arm low forces IDLE on next edge from any state.
//  trigger while in RING/SNOOZE is ignored (no restart).
//  Counter widths: $clog2(RING_SEC+1), $clog2(SNOOZE_MIN*60+1), $clog2(TONE_DIV); no wrap possible.
//  buzz: tone counter runs only in RING; toggles buzz every TONE_DIV clks, starts 0 on RING entry;
//   leaving RING clears buzz and tone counter on the same edge.
//  sec_tick and stop/snooze/set pulses are assumed synchronous to clk; no internal debounce.
// CONFIGURATION
//  SNOOZE_LIMIT_EN defined: snooze counter per event (cleared on IDLE->RING by trigger); snooze
//   in RING when count==MAX_SNOOZE is ignored (keeps ringing until stop/timeout/~arm).
//  SNOOZE_LIMIT_EN undefined: unlimited snoozes; MAX_SNOOZE unused, no count register.
// TESTING (RING_SEC=4, SNOOZE_MIN=1, TONE_DIV=2 for sims)
//  set 07:30, arm=1, now steps 07:29->07:30 -> ringing=1 one clk later, buzz toggles every 2 clks.
//  ringing, 4 sec_ticks with no input -> ringing=0, state IDLE; stays IDLE for rest of 07:30.
//  ringing, snooze -> snoozing=1, buzz=0; 60 sec_ticks -> ringing=1 again; stop -> IDLE.
//  set_alarm with 24:00 or 12:60 -> set_err one-cycle pulse, alarm stays 07:30.
//  stop and snooze in same cycle during RING -> IDLE; arm dropped during SNOOZE -> IDLE next edge.
//  SNOOZE_LIMIT_EN, MAX_SNOOZE=3: 4th snooze ignored, ringing stays 1; rstn low mid-RING -> all outputs 0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm controller: BCD alarm register, minute-edge match trigger, ring/snooze FSM and buzzer tone.
// Optional build macro SNOOZE_LIMIT_EN caps snoozes per alarm event at MAX_SNOOZE.
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int TONE_DIV   = 1000,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sec_tick,
  input  logic [3:0] hourdec_now,
  input  logic [3:0] hourone_now,
  input  logic [3:0] mindec_now,
  input  logic [3:0] minone_now,
  input  logic       set_alarm,
  input  logic [3:0] hourdec_set,
  input  logic [3:0] hourone_set,
  input  logic [3:0] mindec_set,
  input  logic [3:0] minone_set,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzz,
  output logic       set_err
);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_MIN * 60 + 1);
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_MIN * 60);
  localparam logic [TW-1:0] TONE_LAST = TW'(TONE_DIV - 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state;

  logic [3:0]    hourdec_a, hourone_a, mindec_a, minone_a;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snz_cnt;
  logic [TW-1:0] tone_cnt;
  logic          match, match_q, trigger, set_ok, snz_ok;

  assign set_ok = (hourdec_set <= 4'd2) && (hourone_set <= 4'd9) &&
                  (mindec_set <= 4'd5) && (minone_set <= 4'd9) &&
                  !((hourdec_set == 4'd2) && (hourone_set > 4'd3));
  assign match = (hourdec_now == hourdec_a) && (hourone_now == hourone_a) &&
                 (mindec_now == mindec_a) && (minone_now == minone_a);
  // match_q resets to 1 so a time already equal to 00:00 at reset does not ring
  assign trigger = arm & match & ~match_q;

`ifdef SNOOZE_LIMIT_EN
  localparam int NW = $clog2(MAX_SNOOZE + 1);
  logic [NW-1:0] snz_num;
  assign snz_ok = (snz_num != NW'(MAX_SNOOZE));
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   snz_num <= '0;
    else if (state == IDLE && trigger)           snz_num <= '0;
    else if (state == RING && arm && !stop && snooze && snz_ok)
                                                 snz_num <= snz_num + 1'b1;
  end
`else
  assign snz_ok = (MAX_SNOOZE != 0) | 1'b1;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hourdec_a <= '0; hourone_a <= '0; mindec_a <= '0; minone_a <= '0;
      state     <= IDLE;
      ringing   <= 1'b0;
      snoozing  <= 1'b0;
      buzz      <= 1'b0;
      set_err   <= 1'b0;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      tone_cnt  <= '0;
      match_q   <= 1'b1;
    end else begin
      set_err <= set_alarm & ~set_ok;
      if (set_alarm && set_ok) begin
        hourdec_a <= hourdec_set; hourone_a <= hourone_set;
        mindec_a  <= mindec_set;  minone_a  <= minone_set;
      end
      match_q <= match;
      case (state)
        IDLE: if (trigger) begin
          state <= RING; ringing <= 1'b1;
          ring_cnt <= '0; tone_cnt <= '0; buzz <= 1'b0;
        end
        RING: begin
          if (!arm || stop || (sec_tick && ring_cnt == RING_LAST && !(snooze && snz_ok))) begin
            state <= IDLE; ringing <= 1'b0; snoozing <= 1'b0;
            buzz <= 1'b0; tone_cnt <= '0; ring_cnt <= '0; snz_cnt <= '0;
          end else if (snooze && snz_ok) begin
            state <= SNOOZE; ringing <= 1'b0; snoozing <= 1'b1;
            snz_cnt <= SNZ_LOAD; buzz <= 1'b0; tone_cnt <= '0;
          end else begin
            if (sec_tick) ring_cnt <= ring_cnt + 1'b1;
            if (tone_cnt == TONE_LAST) begin
              tone_cnt <= '0; buzz <= ~buzz;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (!arm || stop) begin
            state <= IDLE; snoozing <= 1'b0; snz_cnt <= '0; ring_cnt <= '0;
          end else if (sec_tick) begin
            if (snz_cnt == SW'(1)) begin
              state <= RING; snoozing <= 1'b0; ringing <= 1'b1;
              snz_cnt <= '0; ring_cnt <= '0; tone_cnt <= '0; buzz <= 1'b0;
            end else begin
              snz_cnt <= snz_cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE; ringing <= 1'b0; snoozing <= 1'b0; buzz <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with short timing parameters (RING_SEC=4, SNOOZE_MIN=1, TONE_DIV=2).
module tb_alarm_ctrl;
  logic       clk = 1'b0, rstn = 1'b0, sec_tick = 1'b0;
  logic [3:0] hourdec_now = 0, hourone_now = 0, mindec_now = 0, minone_now = 0;
  logic       set_alarm = 1'b0;
  logic [3:0] hourdec_set = 0, hourone_set = 0, mindec_set = 0, minone_set = 0;
  logic       arm = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic       ringing, snoozing, buzz, set_err;
  int         checks = 0, errors = 0;

  alarm_ctrl #(.RING_SEC(4), .SNOOZE_MIN(1), .TONE_DIV(2), .MAX_SNOOZE(3)) dut (
    .clk(clk), .rstn(rstn), .sec_tick(sec_tick),
    .hourdec_now(hourdec_now), .hourone_now(hourone_now),
    .mindec_now(mindec_now), .minone_now(minone_now),
    .set_alarm(set_alarm), .hourdec_set(hourdec_set), .hourone_set(hourone_set),
    .mindec_set(mindec_set), .minone_set(minone_set),
    .arm(arm), .stop(stop), .snooze(snooze),
    .ringing(ringing), .snoozing(snoozing), .buzz(buzz), .set_err(set_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_now(input logic [3:0] hd, ho, md, mo);
    hourdec_now = hd; hourone_now = ho; mindec_now = md; minone_now = mo;
  endtask

  task automatic load(input logic [3:0] hd, ho, md, mo);
    hourdec_set = hd; hourone_set = ho; mindec_set = md; minone_set = mo;
    set_alarm = 1'b1; tick(); set_alarm = 1'b0;
  endtask

  task automatic sec_pulse();
    sec_tick = 1'b1; tick(); sec_tick = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1; tick(); snooze = 1'b0;
  endtask

  // steps 07:29 -> 07:30 so the minute edge fires the trigger
  task automatic go_ring();
    set_now(0, 7, 2, 9); tick(); tick();
    set_now(0, 7, 3, 0); tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; #2;
    checks++;
    if ({ringing, snoozing, buzz, set_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {ringing, snoozing, buzz, set_err});
    end
    tick(); rstn = 1'b1; tick();
    // now=00:00 equals reset alarm, but match_q starts high so no ring
    arm = 1'b1; tick(); tick();
    checks++;
    if (ringing !== 1'b0) begin
      errors++; $display("FAIL no_ring_after_reset got %b exp 0", ringing);
    end
  endtask

  task automatic test_ring_buzz();
    logic [4:0] exp_buzz;
    set_now(0, 7, 2, 9); tick();
    load(0, 7, 3, 0);
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL set_ok_err got %b exp 0", set_err);
    end
    tick();
    set_now(0, 7, 3, 0); tick();
    checks++;
    if (ringing !== 1'b1 || buzz !== 1'b0) begin
      errors++; $display("FAIL ring_entry got ringing=%b buzz=%b exp 1 0", ringing, buzz);
    end
    exp_buzz = 5'b01100;
    for (int i = 4; i >= 0; i--) begin
      tick();
      checks++;
      if (buzz !== exp_buzz[i]) begin
        errors++; $display("FAIL buzz_seq[%0d] got %b exp %b", 4 - i, buzz, exp_buzz[i]);
      end
    end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 3; i++) sec_pulse();
    checks++;
    if (ringing !== 1'b1) begin
      errors++; $display("FAIL ring_before_timeout got %b exp 1", ringing);
    end
    sec_pulse();
    checks++;
    if (ringing !== 1'b0 || buzz !== 1'b0) begin
      errors++; $display("FAIL timeout got ringing=%b buzz=%b exp 0 0", ringing, buzz);
    end
    repeat (5) tick();
    checks++;
    if (ringing !== 1'b0) begin
      errors++; $display("FAIL stay_idle_same_minute got %b exp 0", ringing);
    end
  endtask

  task automatic test_snooze();
    go_ring();
    repeat (2) tick();
    pulse_snooze();
    checks++;
    if (snoozing !== 1'b1 || ringing !== 1'b0 || buzz !== 1'b0) begin
      errors++; $display("FAIL snooze_entry got %b%b%b exp 100", snoozing, ringing, buzz);
    end
    for (int i = 1; i <= 60; i++) begin
      sec_pulse();
      if (i == 30) begin
        pulse_snooze();
        checks++;
        if (snoozing !== 1'b1) begin
          errors++; $display("FAIL snooze_in_snooze got %b exp 1", snoozing);
        end
      end
      if (i == 59) begin
        checks++;
        if (snoozing !== 1'b1 || ringing !== 1'b0) begin
          errors++; $display("FAIL snooze_59 got %b%b exp 10", snoozing, ringing);
        end
      end
    end
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0) begin
      errors++; $display("FAIL snooze_expire got ringing=%b snoozing=%b exp 1 0", ringing, snoozing);
    end
    pulse_stop();
    checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      errors++; $display("FAIL stop got %b%b exp 00", ringing, snoozing);
    end
  endtask

  task automatic test_bad_set();
    load(2, 4, 0, 0);
    checks++;
    if (set_err !== 1'b1) begin
      errors++; $display("FAIL set_err_2400 got %b exp 1", set_err);
    end
    tick();
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL set_err_width got %b exp 0", set_err);
    end
    load(1, 2, 6, 0);
    checks++;
    if (set_err !== 1'b1) begin
      errors++; $display("FAIL set_err_1260 got %b exp 1", set_err);
    end
    go_ring();
    checks++;
    if (ringing !== 1'b1) begin
      errors++; $display("FAIL alarm_kept_0730 got %b exp 1", ringing);
    end
    pulse_stop();
    load(2, 3, 5, 9);
    checks++;
    if (set_err !== 1'b0) begin
      errors++; $display("FAIL set_ok_2359 got %b exp 0", set_err);
    end
    set_now(2, 3, 5, 8); tick(); tick();
    set_now(2, 3, 5, 9); tick();
    checks++;
    if (ringing !== 1'b1) begin
      errors++; $display("FAIL ring_2359 got %b exp 1", ringing);
    end
    pulse_stop();
    load(0, 7, 3, 0);
  endtask

  task automatic test_stop_snooze_same();
    go_ring();
    stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
    checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      errors++; $display("FAIL stop_and_snooze got %b%b exp 00", ringing, snoozing);
    end
  endtask

  task automatic test_arm_drop();
    go_ring();
    pulse_snooze();
    arm = 1'b0; tick();
    checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0) begin
      errors++; $display("FAIL arm_drop_snooze got %b%b exp 00", ringing, snoozing);
    end
    tick(); arm = 1'b1;
  endtask

  task automatic test_reset_mid_ring();
`ifdef SNOOZE_LIMIT_EN
    go_ring();
    for (int k = 0; k < 3; k++) begin
      pulse_snooze();
      for (int i = 0; i < 60; i++) sec_pulse();
    end
    checks++;
    if (ringing !== 1'b1) begin
      errors++; $display("FAIL third_snooze_return got %b exp 1", ringing);
    end
    pulse_snooze();
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0) begin
      errors++; $display("FAIL fourth_snooze got %b%b exp 10", ringing, snoozing);
    end
`else
    go_ring();
`endif
    tick(); tick();
    rstn = 1'b0; #2;
    checks++;
    if ({ringing, snoozing, buzz, set_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_ring got %b exp 0000", {ringing, snoozing, buzz, set_err});
    end
    tick(); rstn = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_ring_buzz();
    test_timeout();
    test_snooze();
    test_bad_set();
    test_stop_snooze_same();
    test_arm_drop();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
